// File: rtl/ser_word_8_pkg.sv
// Shared types and constants for the ser_word_8 parallel-to-serial front end.
package ser_word_8_pkg;

  localparam int unsigned W    = 8;
  localparam int unsigned SELW = 3;
  localparam int unsigned GAPW = 4;

  localparam logic [SELW-1:0] CNT_FIRST = SELW'(0);
  localparam logic [SELW-1:0] CNT_LAST  = SELW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  // Decoded control outputs, produced together by the output process.
  typedef struct packed {
    logic ser_valid;
    logic frame_start;
    logic frame_end;
    logic busy;
    logic in_ready;
  } ser_flags_t;

  // Bit select for a given position in the frame; MSB-first walks 7..0.
  function automatic logic [SELW-1:0] bit_sel(input logic [SELW-1:0] cnt,
                                              input logic            msb_first);
    return cnt ^ {SELW{msb_first}};
  endfunction

  // Gap counter load value; the final gap cycle is the one where the counter reads 0.
  function automatic logic [GAPW-1:0] gap_load(input int unsigned gap_cycles);
    return (gap_cycles == 0) ? '0 : GAPW'(gap_cycles - 1);
  endfunction

endpackage

// File: rtl/ser_word_8_mux.sv
// 8:1 bit select tree: picks one bit of the held word.
module ser_word_8_mux
  import ser_word_8_pkg::*;
(
  input  logic [W-1:0]    i,
  input  logic [SELW-1:0] s,
  output logic            f
);

  always_comb begin
    f = 1'b0;
    case (s)
      3'd0:    f = i[0];
      3'd1:    f = i[1];
      3'd2:    f = i[2];
      3'd3:    f = i[3];
      3'd4:    f = i[4];
      3'd5:    f = i[5];
      3'd6:    f = i[6];
      3'd7:    f = i[7];
      default: f = 1'b0;
    endcase
  end

endmodule

// File: rtl/ser_word_8.sv
// Parallel-to-serial front end: accepts a byte over valid/ready and emits it one bit
// per enabled cycle, optionally with forced idle gaps between frames.
module ser_word_8
  import ser_word_8_pkg::*;
#(
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         ser_en,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         frame_start,
  output logic         frame_end,
  output logic         busy
);

  localparam bit              GAP_EN   = (GAP_CYCLES != 0);
  localparam logic [GAPW-1:0] GAP_LOAD = gap_load(GAP_CYCLES);

  state_e          state_q, state_d;
  logic [W-1:0]    word_q, word_d;
  logic [SELW-1:0] cnt_q, cnt_d;
  logic [GAPW-1:0] gap_q, gap_d;

  logic            accept;
  logic            cnt_last;
  logic            gap_last;
  logic [SELW-1:0] sel;
  logic            raw_bit;
  ser_flags_t      flags;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign gap_last = (gap_q == '0);
  assign accept   = in_valid & flags.in_ready;

  // State register, including the held word and both counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state and counter updates; an accept always restarts the frame at bit 0.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          word_d  = in_data;
          cnt_d   = CNT_FIRST;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (ser_en) begin
          if (!cnt_last) begin
            cnt_d = cnt_q + SELW'(1);
          end else if (GAP_EN) begin
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end else if (accept) begin
            word_d  = in_data;
            cnt_d   = CNT_FIRST;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (!gap_last) begin
          gap_d = gap_q - GAPW'(1);
        end else if (accept) begin
          word_d  = in_data;
          cnt_d   = CNT_FIRST;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state; in_ready never looks at in_valid.
  always_comb begin
    flags = '0;
    case (state_q)
      S_IDLE: begin
        flags.in_ready = 1'b1;
      end
      S_SHIFT: begin
        flags.ser_valid   = 1'b1;
        flags.busy        = 1'b1;
        flags.frame_start = (cnt_q == CNT_FIRST);
        flags.frame_end   = cnt_last;
        flags.in_ready    = !GAP_EN && cnt_last && ser_en;
      end
      S_GAP: begin
        flags.busy     = 1'b1;
        flags.in_ready = gap_last;
      end
      default: flags = '0;
    endcase
  end

  assign sel = bit_sel(cnt_q, MSB_FIRST);

  ser_word_8_mux u_mux (
    .i (word_q),
    .s (sel),
    .f (raw_bit)
  );

  assign ser_out     = raw_bit & flags.ser_valid;
  assign ser_valid   = flags.ser_valid;
  assign frame_start = flags.frame_start;
  assign frame_end   = flags.frame_end;
  assign busy        = flags.busy;
  assign in_ready    = flags.in_ready;

endmodule

// File: tb/tb_ser_word_8.sv
// Bench for ser_word_8: three configurations checked every cycle against a frame-level model.
module tb_ser_word_8;

  logic       clk;
  logic       rst_n;
  logic [2:0] in_valid, in_ready, ser_en, ser_out, ser_valid, frame_start, frame_end, busy;
  logic [7:0] in_data [3];

  int errors;
  int checks;

  // Model: mode 0 idle, 1 sending bit pos of word, 2 gap with gleft cycles remaining
  int         m_mode  [3];
  int         m_pos   [3];
  int         m_gleft [3];
  logic [7:0] m_word  [3];

  logic [2:0] obs_out, obs_fs, obs_fe, obs_valid, obs_ready;

  ser_word_8 #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_en(ser_en[0]), .ser_out(ser_out[0]),
    .ser_valid(ser_valid[0]), .frame_start(frame_start[0]), .frame_end(frame_end[0]),
    .busy(busy[0]));

  ser_word_8 #(.MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_en(ser_en[1]), .ser_out(ser_out[1]),
    .ser_valid(ser_valid[1]), .frame_start(frame_start[1]), .frame_end(frame_end[1]),
    .busy(busy[1]));

  ser_word_8 #(.MSB_FIRST(1'b1), .GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .ser_en(ser_en[2]), .ser_out(ser_out[2]),
    .ser_valid(ser_valid[2]), .frame_start(frame_start[2]), .frame_end(frame_end[2]),
    .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int gap_of(input int i);
    return (i == 2) ? 3 : 0;
  endfunction

  function automatic bit msb_of(input int i);
    return i != 0;
  endfunction

  function automatic logic exp_ready(input int i);
    case (m_mode[i])
      0:       return 1'b1;
      1:       return (gap_of(i) == 0) && (m_pos[i] == 7) && (ser_en[i] == 1'b1);
      default: return m_gleft[i] == 1;
    endcase
  endfunction

  function automatic logic exp_out(input int i);
    if (m_mode[i] != 1) return 1'b0;
    return msb_of(i) ? m_word[i][7 - m_pos[i]] : m_word[i][m_pos[i]];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i]  = 0;
      m_pos[i]   = 0;
      m_gleft[i] = 0;
      m_word[i]  = 8'h00;
    end
  endtask

  task automatic model_step(input int i);
    logic acc;
    acc = in_valid[i] & exp_ready(i);
    case (m_mode[i])
      0: if (acc) begin m_mode[i] = 1; m_pos[i] = 0; m_word[i] = in_data[i]; end
      1: begin
        if (ser_en[i]) begin
          if (m_pos[i] < 7) m_pos[i]++;
          else if (gap_of(i) > 0) begin m_mode[i] = 2; m_gleft[i] = gap_of(i); end
          else if (acc) begin m_pos[i] = 0; m_word[i] = in_data[i]; end
          else m_mode[i] = 0;
        end
      end
      default: begin
        if (m_gleft[i] > 1) m_gleft[i]--;
        else if (acc) begin m_mode[i] = 1; m_pos[i] = 0; m_word[i] = in_data[i]; end
        else m_mode[i] = 0;
      end
    endcase
  endtask

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got 'h%0h want 'h%0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("in_ready",    i, 32'(in_ready[i]),    32'(exp_ready(i)));
      chk("ser_valid",   i, 32'(ser_valid[i]),   32'(m_mode[i] == 1));
      chk("ser_out",     i, 32'(ser_out[i]),     32'(exp_out(i)));
      chk("frame_start", i, 32'(frame_start[i]), 32'(m_mode[i] == 1 && m_pos[i] == 0));
      chk("frame_end",   i, 32'(frame_end[i]),   32'(m_mode[i] == 1 && m_pos[i] == 7));
      chk("busy",        i, 32'(busy[i]),        32'(m_mode[i] != 0));
    end
    obs_out   = ser_out;
    obs_fs    = frame_start;
    obs_fe    = frame_end;
    obs_valid = ser_valid;
    obs_ready = in_ready;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
  endtask

  task automatic drain();
    in_valid = 3'b000;
    ser_en   = 3'b111;
    repeat (20) cycle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},    0, 32'(in_ready),    32'(3'b111));
    chk({tag, "_ser_valid"},   0, 32'(ser_valid),   32'(3'b000));
    chk({tag, "_ser_out"},     0, 32'(ser_out),     32'(3'b000));
    chk({tag, "_frame_start"}, 0, 32'(frame_start), 32'(3'b000));
    chk({tag, "_frame_end"},   0, 32'(frame_end),   32'(3'b000));
    chk({tag, "_busy"},        0, 32'(busy),        32'(3'b000));
  endtask

  initial begin
    logic [7:0]  v8, s8, e8, r8;
    logic [15:0] s16, r16;
    logic [18:0] v19, r19, o19;
    logic [12:0] s13, v13, e13;
    int          vcnt;

    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    in_valid = 3'b000;
    ser_en   = 3'b111;
    for (int i = 0; i < 3; i++) in_data[i] = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LSB-first 8'hA5 with ser_en held high
    in_valid[0] = 1'b1; in_data[0] = 8'hA5;
    cycle();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      v8[k] = obs_out[0]; s8[k] = obs_fs[0]; e8[k] = obs_fe[0];
    end
    chk("t1_bits",  0, 32'(v8), 32'(8'hA5));
    chk("t1_start", 0, 32'(s8), 32'(8'h01));
    chk("t1_end",   0, 32'(e8), 32'(8'h80));
    drain();

    // MSB-first back-to-back 8'h81, 8'h3C
    in_valid[1] = 1'b1; in_data[1] = 8'h81;
    cycle();
    in_data[1] = 8'h3C;
    vcnt = 0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      s16  = {s16[14:0], obs_out[1]};
      r16  = {r16[14:0], obs_ready[1]};
      vcnt += int'(obs_valid[1]);
      if (k == 7) in_valid[1] = 1'b0;
    end
    chk("t2_bits",  1, 32'(s16), 32'(16'b1000_0001_0011_1100));
    chk("t2_ready", 1, 32'(r16), 32'(16'b0000_0001_0000_0001));
    chk("t2_valid", 1, 32'(vcnt), 32'd16);
    drain();

    // Three forced gap cycles between two queued words
    in_valid[2] = 1'b1; in_data[2] = 8'h5A;
    cycle();
    in_data[2] = 8'hC3;
    for (int k = 0; k < 19; k++) begin
      cycle();
      v19 = {v19[17:0], obs_valid[2]};
      r19 = {r19[17:0], obs_ready[2]};
      o19 = {o19[17:0], obs_out[2]};
      if (k == 10) in_valid[2] = 1'b0;
    end
    chk("t3_valid", 2, 32'(v19), 32'(19'h7F8FF));
    chk("t3_ready", 2, 32'(r19), 32'(19'h00100));
    chk("t3_bits",  2, 32'(o19), 32'(19'h2D0C3));
    drain();

    // Four-cycle stall on the fourth bit of 8'hF0, MSB first
    in_valid[1] = 1'b1; in_data[1] = 8'hF0;
    cycle();
    in_valid[1] = 1'b0;
    for (int k = 0; k < 13; k++) begin
      ser_en[1] = !(k >= 3 && k <= 6);
      cycle();
      s13 = {s13[11:0], obs_out[1]};
      v13 = {v13[11:0], obs_valid[1]};
      e13 = {e13[11:0], obs_fe[1]};
    end
    ser_en[1] = 1'b1;
    chk("t4_bits",  1, 32'(s13), 32'(13'h1FE0));
    chk("t4_valid", 1, 32'(v13), 32'(13'h1FFE));
    chk("t4_end",   1, 32'(e13), 32'(13'h0002));
    drain();

    // Asynchronous reset while bit 5 is on the wire
    in_valid[0] = 1'b1; in_data[0] = 8'h6B;
    cycle();
    in_valid[0] = 1'b0;
    repeat (5) cycle();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_async");
    model_reset();
    #1;
    rst_n = 1'b1;
    #1;
    chk("t5_ready_release", 0, 32'(in_ready), 32'(3'b111));
    @(posedge clk);
    #1;
    in_valid[0] = 1'b1; in_data[0] = 8'h6B;
    cycle();
    in_valid[0] = 1'b0;
    cycle();
    chk("t5_first_bit", 0, 32'(obs_out[0]), 32'd1);
    chk("t5_first_fs",  0, 32'(obs_fs[0]),  32'd1);
    drain();

    // in_data churns mid-frame with in_valid held
    in_valid[0] = 1'b1; in_data[0] = 8'h3C;
    cycle();
    for (int k = 0; k < 8; k++) begin
      in_data[0] = 8'($urandom);
      cycle();
      v8[k] = obs_out[0]; r8[k] = obs_ready[0];
    end
    in_valid[0] = 1'b0;
    chk("t6_bits",  0, 32'(v8), 32'(8'h3C));
    chk("t6_ready", 0, 32'(r8), 32'(8'h80));
    drain();

    // Randomized traffic on all three configurations
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        in_valid[i] = ($urandom_range(0, 9) < 6);
        in_data[i]  = 8'($urandom);
        ser_en[i]   = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
